// File: rtl/systolic_ctrl.sv
// Job sequencer for the weight-stationary PE array: clear, weight shift-in,
// skewed input streaming, pipeline drain and result handshake.
module systolic_ctrl #(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int K_WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [K_WIDTH-1:0] k_len,
    input  logic               reuse_weights,
    output logic               busy,
    output logic               done,
    output logic               w_req,
    output logic               weight_load,
    output logic               acc_clear,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               data_gate,
    output logic [COLS-1:0]    acc_enable,
    output logic               result_valid,
    input  logic               result_ready
);

    localparam int WCNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DCNT_W = (COLS > 2) ? $clog2(COLS - 1) : 1;
    localparam int SKEW_W = (COLS > 1) ? COLS - 1 : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_WLOAD, S_COMPUTE, S_DRAIN, S_RESULT
    } state_t;

    state_t             r_state;
    logic [K_WIDTH-1:0] r_k_len;
    logic               r_reuse;
    logic [K_WIDTH-1:0] r_vec_cnt;
    logic [WCNT_W-1:0]  r_wcnt;
    logic [DCNT_W-1:0]  r_dcnt;
    logic [SKEW_W-1:0]  r_skew;
    logic               r_busy;
    logic               r_acc_clear;
    logic               r_w_req;
    logic               r_weight_load;
    logic               r_in_ready;
    logic               r_result_valid;

    logic               w_fire;
    logic               w_handshake;
    logic [COLS-1:0]    w_acc_en;

    assign w_fire      = in_valid & r_in_ready;
    assign w_handshake = r_result_valid & result_ready;

    // Column c sees the fire of c cycles ago, matching the array's data skew.
    if (COLS == 1) begin : g_noskew
        assign w_acc_en = w_fire;
    end else begin : g_skew
        assign w_acc_en = {r_skew, w_fire};
    end

    assign busy         = r_busy;
    assign done         = w_handshake;
    assign w_req        = r_w_req;
    assign weight_load  = r_weight_load;
    assign acc_clear    = r_acc_clear;
    assign in_ready     = r_in_ready;
    assign data_gate    = w_fire;
    assign acc_enable   = w_acc_en;
    assign result_valid = r_result_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_k_len        <= '0;
            r_reuse        <= 1'b0;
            r_vec_cnt      <= '0;
            r_wcnt         <= '0;
            r_dcnt         <= '0;
            r_skew         <= '0;
            r_busy         <= 1'b0;
            r_acc_clear    <= 1'b0;
            r_w_req        <= 1'b0;
            r_weight_load  <= 1'b0;
            r_in_ready     <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            r_skew <= SKEW_W'({r_skew, w_fire});
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_k_len     <= k_len;
                        r_reuse     <= reuse_weights;
                        r_busy      <= 1'b1;
                        r_acc_clear <= 1'b1;
                        r_state     <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_acc_clear <= 1'b0;
                    if (!r_reuse) begin
                        r_wcnt        <= '0;
                        r_w_req       <= 1'b1;
                        r_weight_load <= (ROWS == 1);
                        r_state       <= S_WLOAD;
                    end else if (r_k_len != '0) begin
                        r_vec_cnt  <= '0;
                        r_in_ready <= 1'b1;
                        r_state    <= S_COMPUTE;
                    end else begin
                        r_result_valid <= 1'b1;
                        r_state        <= S_RESULT;
                    end
                end
                S_WLOAD: begin
                    if (r_wcnt == WCNT_W'(ROWS - 1)) begin
                        r_w_req       <= 1'b0;
                        r_weight_load <= 1'b0;
                        if (r_k_len != '0) begin
                            r_vec_cnt  <= '0;
                            r_in_ready <= 1'b1;
                            r_state    <= S_COMPUTE;
                        end else begin
                            r_result_valid <= 1'b1;
                            r_state        <= S_RESULT;
                        end
                    end else begin
                        r_wcnt        <= r_wcnt + WCNT_W'(1);
                        r_weight_load <= (r_wcnt == WCNT_W'(ROWS - 2));
                    end
                end
                S_COMPUTE: begin
                    if (w_fire) begin
                        r_vec_cnt <= r_vec_cnt + K_WIDTH'(1);
                        if (r_vec_cnt == r_k_len - K_WIDTH'(1)) begin
                            r_in_ready <= 1'b0;
                            if (COLS == 1) begin
                                r_result_valid <= 1'b1;
                                r_state        <= S_RESULT;
                            end else begin
                                r_dcnt  <= '0;
                                r_state <= S_DRAIN;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_dcnt == DCNT_W'(COLS - 2)) begin
                        r_result_valid <= 1'b1;
                        r_state        <= S_RESULT;
                    end else begin
                        r_dcnt <= r_dcnt + DCNT_W'(1);
                    end
                end
                S_RESULT: begin
                    if (result_ready) begin
                        r_result_valid <= 1'b0;
                        r_busy         <= 1'b0;
                        r_state        <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: a timeline model (phase boundaries computed from the
// job's accept time, k and fire history) is checked every cycle, plus literal latencies.
module tb_systolic_ctrl;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int KW   = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [KW-1:0]   k_len;
    logic            reuse_weights;
    logic            in_valid;
    logic            result_ready;
    logic            busy, done, w_req, weight_load, acc_clear;
    logic            in_ready, data_gate, result_valid;
    logic [COLS-1:0] acc_enable;

    int n_vec = 0;
    int n_err = 0;

    systolic_ctrl #(.ROWS(ROWS), .COLS(COLS), .K_WIDTH(KW)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .reuse_weights(reuse_weights), .busy(busy), .done(done),
        .w_req(w_req), .weight_load(weight_load), .acc_clear(acc_clear),
        .in_valid(in_valid), .in_ready(in_ready), .data_gate(data_gate),
        .acc_enable(acc_enable), .result_valid(result_valid),
        .result_ready(result_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    // Model state: job timeline measured in cycles since accept (t=1 is the clear cycle).
    bit m_act = 1'b0;
    int m_t, m_fires, m_last, m_k;
    bit m_reuse;
    bit m_hist[COLS];

    always @(negedge clk) begin : cmp
        int              cs;
        logic            e_busy, e_clr, e_wreq, e_wl, e_ir, e_fire, e_rv, e_done;
        logic [COLS-1:0] e_en;
        e_busy = 0; e_clr = 0; e_wreq = 0; e_wl = 0; e_ir = 0;
        e_fire = 0; e_rv = 0; e_done = 0; e_en = '0;
        cs = 2 + (m_reuse ? 0 : ROWS);
        if (!rst) begin
            e_busy = m_act;
            e_clr  = m_act && m_t == 1;
            e_wreq = m_act && !m_reuse && m_t >= 2 && m_t <= 1 + ROWS;
            e_wl   = m_act && !m_reuse && m_t == 1 + ROWS;
            e_ir   = m_act && m_k != 0 && m_t >= cs && m_fires < m_k;
            e_fire = e_ir && in_valid;
            e_rv   = m_act && ((m_k == 0) ? (m_t >= cs)
                                          : (m_fires == m_k && m_t >= m_last + COLS));
            e_done = e_rv && result_ready;
            e_en[0] = e_fire;
            for (int c = 1; c < COLS; c++) e_en[c] = m_hist[c-1];
        end
        chk("busy", busy, e_busy);
        chk("acc_clear", acc_clear, e_clr);
        chk("w_req", w_req, e_wreq);
        chk("weight_load", weight_load, e_wl);
        chk("in_ready", in_ready, e_ir);
        chk("data_gate", data_gate, e_fire);
        chk("acc_enable", acc_enable, e_en);
        chk("result_valid", result_valid, e_rv);
        chk("done", done, e_done);
        if (rst) begin
            m_act = 0;
            for (int c = 0; c < COLS; c++) m_hist[c] = 0;
        end else begin
            for (int c = COLS - 1; c > 0; c--) m_hist[c] = m_hist[c-1];
            m_hist[0] = e_fire;
            if (m_act) begin
                if (e_fire) begin
                    m_fires++;
                    if (m_fires == m_k) m_last = m_t;
                end
                if (e_done) m_act = 0;
                m_t++;
            end else if (start) begin
                m_act = 1; m_t = 1; m_fires = 0;
                m_k = int'(k_len); m_reuse = reuse_weights;
            end
        end
    end

    // vmode: 0 valid tied 1, 1 single bubble on 2nd vector, 2 random.
    // rrmode: 0 ready tied 1, N>0 held low for N result_valid cycles, <0 random.
    task automatic run_job(input int k, input bit rw, input int vmode, input int rrmode,
                           input bit pulse, output int lat, output int nf,
                           output int nw, output int ne3);
        int cyc = 0;
        int rvc = 0;
        bit seen = 0;
        bit bub = 0;
        nf = 0; nw = 0; ne3 = 0; lat = -1;
        @(posedge clk); #1;
        start = 1'b1; k_len = KW'(k); reuse_weights = rw;
        in_valid = (vmode == 2) ? (($urandom & 1) != 0) : 1'b1;
        result_ready = (rrmode == 0) ? 1'b1 : (rrmode < 0) ? (($urandom & 1) != 0) : 1'b0;
        while (!seen && cyc < 1000) begin
            @(negedge clk);
            nf  += int'(data_gate);
            nw  += int'(w_req);
            ne3 += int'(acc_enable[COLS-1]);
            if (result_valid) rvc++;
            if (!in_valid && in_ready) bub = 1;
            if (done) begin
                seen = 1;
                lat  = cyc;
            end else begin
                @(posedge clk); #1;
                cyc++;
                start = pulse ? (($urandom & 1) != 0) : 1'b0;
                if (pulse) begin
                    k_len = KW'($urandom);
                    reuse_weights = ($urandom & 1) != 0;
                end
                case (vmode)
                    0:       in_valid = 1'b1;
                    1:       in_valid = !(nf == 1 && !bub);
                    default: in_valid = ($urandom % 3) != 0;
                endcase
                if (rrmode == 0)     result_ready = 1'b1;
                else if (rrmode > 0) result_ready = (rvc >= rrmode);
                else                 result_ready = ($urandom & 1) != 0;
            end
        end
        if (!seen) begin
            n_vec++; n_err++;
            $display("FAIL job_timeout: got no done, expected done within 1000 cycles");
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
        end
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b0; result_ready = 1'b0;
    endtask

    initial begin : stim
        int lat, nf, nw, ne3, k;
        rst = 1'b1; start = 1'b0; k_len = '0; reuse_weights = 1'b0;
        in_valid = 1'b0; result_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_outputs", {w_req, weight_load, acc_clear, in_ready, result_valid}, 0);
        chk("reset_acc_enable", acc_enable, 0);
        rst = 1'b0;

        run_job(3, 0, 0, 0, 0, lat, nf, nw, ne3);
        chk("base_latency", lat, 12);
        chk("base_fires", nf, 3);
        chk("base_wreq_cycles", nw, 4);
        chk("base_en3_pulses", ne3, 3);

        run_job(3, 0, 1, 0, 0, lat, nf, nw, ne3);
        chk("bubble_latency", lat, 13);
        chk("bubble_fires", nf, 3);
        chk("bubble_en3_pulses", ne3, 3);

        run_job(2, 1, 0, 0, 0, lat, nf, nw, ne3);
        chk("reuse_latency", lat, 7);
        chk("reuse_wreq_cycles", nw, 0);
        chk("reuse_fires", nf, 2);

        run_job(0, 0, 0, 0, 0, lat, nf, nw, ne3);
        chk("k0_latency", lat, 6);
        chk("k0_fires", nf, 0);
        chk("k0_wreq_cycles", nw, 4);
        chk("k0_en3_pulses", ne3, 0);

        run_job(3, 1, 0, 5, 1, lat, nf, nw, ne3);
        chk("hold_latency", lat, 13);
        chk("hold_fires", nf, 3);

        // Reset in the middle of COMPUTE after two fires.
        @(posedge clk); #1;
        start = 1'b1; k_len = 16'd5; reuse_weights = 1'b0;
        in_valid = 1'b1; result_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nf = 0;
        for (int i = 0; i < 50 && nf < 2; i++) begin
            @(negedge clk);
            nf += int'(data_gate);
        end
        chk("rst_prefires", nf, 2);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_outputs", {in_ready, data_gate, result_valid, done}, 0);
        chk("rst_mid_acc_enable", acc_enable, 0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; result_ready = 1'b0;

        run_job(3, 0, 0, 0, 0, lat, nf, nw, ne3);
        chk("post_rst_latency", lat, 12);
        chk("post_rst_fires", nf, 3);

        for (int j = 0; j < 15; j++) begin
            k = $urandom_range(0, 12);
            run_job(k, ($urandom & 1) != 0, 2, -1, 1, lat, nf, nw, ne3);
            chk("rand_fires", nf, k);
            chk("rand_en3_pulses", ne3, k);
        end

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/systolic_ctrl.md
Name: systolic_ctrl

Overview:
- Sequencer for the weight-stationary PE array.
- One job runs: clear accumulators, shift in and latch weights, stream K input vectors with per-column skewed accumulate enables, drain the pipeline, hand results off.
- Sits between the local buffers (weight and input sources, result sink) and the broadcast control pins of the array.

Parameters:
- ROWS, 4: PE rows; weight shift depth.
- COLS, 4: PE columns; data skew depth.
- K_WIDTH, 16: width of the accumulation-length field.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  job request; sampled only in IDLE.
- k_len  input  K_WIDTH  number of input vectors to accumulate; captured on accepted start.
- reuse_weights  input  1  captured on accepted start; 1 skips the weight phase.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse on the result handshake.
- w_req  output  1  weight source must present weight word for this cycle; no stall allowed.
- weight_load  output  1  broadcast to all PEs' weight_load.
- acc_clear  output  1  broadcast to all PEs' acc_clear.
- in_valid  input  1  input vector available.
- in_ready  output  1  controller accepts an input vector.
- data_gate  output  1  array input mux: 1 passes vector, 0 injects zeros.
- acc_enable  output  COLS  per-column accumulate enable.
- result_valid  output  1  accumulators hold the final result.
- result_ready  input  1  result sink consumed the result.

Behaviour:
- Reset: all outputs 0; state IDLE; all counters and the skew shift register 0. Reset mid-job returns to IDLE immediately, discards the job and emits no done.
- States: IDLE, CLEAR, WLOAD, COMPUTE, DRAIN, RESULT.
- IDLE: when start=1, capture k_len and reuse_weights and go to CLEAR.
- CLEAR: exactly 1 cycle with acc_clear=1.
  - Next state is WLOAD if reuse_weights=0.
  - Else COMPUTE if k_len!=0.
  - Else RESULT.
- WLOAD: exactly ROWS cycles, w_req=1 in each.
  - The source feeds the bottom-row weight first.
  - weight_load=1 only in the last (ROWS-th) cycle, so row r latches the word fed in cycle ROWS-1-r.
  - Next state is COMPUTE if k_len!=0, else RESULT.
- COMPUTE: in_ready=1.
  - fire = in_valid & in_ready; data_gate = fire.
  - Each fire increments vec_cnt.
  - When the k_len-th fire occurs, go to DRAIN; in_ready drops the next cycle.
  - in_valid=0 creates a bubble; zeros enter the array and no enable is issued.
- Skew register:
  - acc_enable[0] = fire, combinational in the same cycle.
  - acc_enable[c] = fire delayed by c cycles, via a COLS-1 deep shift register that advances every cycle in all states.
- DRAIN: lasts COLS-1 cycles; the shift register flushes. If COLS=1, go straight to RESULT.
- RESULT:
  - result_valid=1 and held until result_ready=1.
  - On handshake: done=1 for that cycle, return to IDLE.
  - result_ready=1 on the first RESULT cycle completes in that same cycle.
- Outside their states: acc_clear, weight_load, w_req, in_ready and result_valid are 0.
- start is ignored while busy=1; start=1 in the cycle done pulses is not accepted.
- Counters:
  - vec_cnt is K_WIDTH bits, compared against captured k_len; k_len=2^K_WIDTH-1 is valid.
  - The WLOAD and DRAIN counters are clog2 sized, with minimum width 1.
- Latency, no bubbles, result_ready tied 1:
  - start to done = 1 + ROWS + k_len + (COLS-1) + 1 cycles.
  - With reuse_weights=1, drop the ROWS term.

Test Plan:
- ROWS=COLS=4, k_len=3, reuse=0, in_valid tied 1, result_ready=1:
  - acc_clear at cycle 1; w_req cycles 2-5; weight_load at cycle 5; fires at cycles 6-8.
  - acc_enable[3] high at cycles 9-11; result_valid and done at cycle 12.
  - With weights 1..16 and inputs all 1, the array sums match the golden model.
- Same job with in_valid=0 on the 2nd vector:
  - Exactly 3 fires; the acc_enable bubble appears in every column shifted by c cycles.
  - done is one cycle later; accumulators match the no-bubble run.
- reuse_weights=1, k_len=2: no w_req or weight_load; done at cycle 1+2+3+1=7; prior weights are used.
- k_len=0, reuse=0: clear, then weight load, then RESULT; accumulators read 0; in_ready never asserted.
- result_ready held 0 for 5 cycles: result_valid stays 1, done pulses once on release; start pulses during busy are ignored.
- rst asserted in COMPUTE after 2 fires: all outputs 0 the same cycle, state IDLE; a fresh start then runs a normal job.
